// File: rtl/cpu_types_pkg.sv
// Shared core types: register index and hazard controller FSM encoding.
package cpu_types_pkg;

   localparam int HAZ_STATE_W = 3;

   typedef logic [4:0] regbits_t;

   typedef enum logic [HAZ_STATE_W-1:0] {
      RUN      = 3'd0,
      LU_STALL = 3'd1,
      DWAIT    = 3'd2,
      HALTED   = 3'd3
   } hazard_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of all non-clock hazard controller signals.
// Performance counter signals exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_ctrl_if;
   import cpu_types_pkg::*;

   logic       RST;
   regbits_t   rs1_ID, rs2_ID, wsel_EX;
   logic       MemRead_EX, RegWr_EX;
   logic       dREN_MEM, dWEN_MEM, dhit, ihit;
   logic       redirect_EX, halt_WB;
   logic       pc_en, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB;
   logic       flush_IF_ID, flush_ID_EX, halt;
   logic [2:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] lu_stall_cnt, dwait_cnt, redirect_cnt;
`endif

   modport ctrl (
      input  RST, rs1_ID, rs2_ID, wsel_EX, MemRead_EX, RegWr_EX,
             dREN_MEM, dWEN_MEM, dhit, ihit, redirect_EX, halt_WB,
      output pc_en, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB,
             flush_IF_ID, flush_ID_EX, halt, state_o
`ifdef HAZARD_PERF_CNT_EN
      , output lu_stall_cnt, dwait_cnt, redirect_cnt
`endif
   );

   modport tb (
      output RST, rs1_ID, rs2_ID, wsel_EX, MemRead_EX, RegWr_EX,
             dREN_MEM, dWEN_MEM, dhit, ihit, redirect_EX, halt_WB,
      input  pc_en, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB,
             flush_IF_ID, flush_ID_EX, halt, state_o
`ifdef HAZARD_PERF_CNT_EN
      , input lu_stall_cnt, dwait_cnt, redirect_cnt
`endif
   );

endinterface

// File: rtl/hazard_perf_counters.sv
// Saturating 32-bit event counters for the hazard controller; frozen while halted.
module hazard_perf_counters (
   input  logic        CLK,
   input  logic        RST,
   input  logic        freeze,
   input  logic        lu_win,
   input  logic        dwait_win,
   input  logic        redirect_win,
   output logic [31:0] lu_stall_cnt,
   output logic [31:0] dwait_cnt,
   output logic [31:0] redirect_cnt
);

   logic [31:0] lu_cnt_q, lu_cnt_d;
   logic [31:0] dw_cnt_q, dw_cnt_d;
   logic [31:0] rd_cnt_q, rd_cnt_d;

   always_comb begin
      lu_cnt_d = lu_cnt_q;
      dw_cnt_d = dw_cnt_q;
      rd_cnt_d = rd_cnt_q;
      if (!freeze) begin
         if (lu_win && lu_cnt_q != '1) lu_cnt_d = lu_cnt_q + 32'd1;
         if (dwait_win && dw_cnt_q != '1) dw_cnt_d = dw_cnt_q + 32'd1;
         if (redirect_win && rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         lu_cnt_q <= '0;
         dw_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else begin
         lu_cnt_q <= lu_cnt_d;
         dw_cnt_q <= dw_cnt_d;
         rd_cnt_q <= rd_cnt_d;
      end
   end

   assign lu_stall_cnt = lu_cnt_q;
   assign dwait_cnt    = dw_cnt_q;
   assign redirect_cnt = rd_cnt_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline stall/flush sequencer for the 5-stage core (load-use, dmem wait, ifetch miss, redirect, halt).
// Define HAZARD_PERF_CNT_EN to add saturating lu_stall/dwait/redirect cycle counters.
module hazard_ctrl_unit
   import cpu_types_pkg::*;
#(
   parameter int LOADUSE_BUBBLES = 1,
   parameter int BUB_CNT_W       = 3
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [4:0]  rs1_ID,
   input  logic [4:0]  rs2_ID,
   input  logic [4:0]  wsel_EX,
   input  logic        MemRead_EX,
   input  logic        RegWr_EX,
   input  logic        dREN_MEM,
   input  logic        dWEN_MEM,
   input  logic        dhit,
   input  logic        ihit,
   input  logic        redirect_EX,
   input  logic        halt_WB,
   output logic        pc_en,
   output logic        en_IF_ID,
   output logic        en_ID_EX,
   output logic        en_EX_MEM,
   output logic        en_MEM_WB,
   output logic        flush_IF_ID,
   output logic        flush_ID_EX,
   output logic        halt,
   output logic [2:0]  state_o
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] lu_stall_cnt,
   output logic [31:0] dwait_cnt,
   output logic [31:0] redirect_cnt
`endif
);

   hazard_state_t        state_q, state_d;
   logic [BUB_CNT_W-1:0] cnt_q, cnt_d;
   logic                 dwait, lu_hit;

   always_comb begin
      dwait  = (dREN_MEM | dWEN_MEM) & ~dhit;
      lu_hit = MemRead_EX & RegWr_EX & (wsel_EX != 5'd0) &
               ((wsel_EX == rs1_ID) | (wsel_EX == rs2_ID));
   end

   // On the dhit release cycle with no pending bubbles, held EX/ID hazards are evaluated as in RUN.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_en       = 1'b1;
      en_IF_ID    = 1'b1;
      en_ID_EX    = 1'b1;
      en_EX_MEM   = 1'b1;
      en_MEM_WB   = 1'b1;
      flush_IF_ID = 1'b0;
      flush_ID_EX = 1'b0;
      if (state_q == HALTED) begin
         pc_en     = 1'b0;
         en_IF_ID  = 1'b0;
         en_ID_EX  = 1'b0;
         en_EX_MEM = 1'b0;
         en_MEM_WB = 1'b0;
      end else begin
         if (dwait) begin
            pc_en     = 1'b0;
            en_IF_ID  = 1'b0;
            en_ID_EX  = 1'b0;
            en_EX_MEM = 1'b0;
            en_MEM_WB = 1'b0;
            state_d   = DWAIT;
         end else if (redirect_EX) begin
            flush_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
            state_d     = RUN;
            cnt_d       = '0;
         end else if (state_q == LU_STALL) begin
            pc_en       = 1'b0;
            en_IF_ID    = 1'b0;
            flush_ID_EX = 1'b1;
            cnt_d       = cnt_q - BUB_CNT_W'(1);
            state_d     = (cnt_q == BUB_CNT_W'(1)) ? RUN : LU_STALL;
         end else if (state_q == DWAIT && cnt_q != '0) begin
            state_d = LU_STALL;
         end else if (lu_hit) begin
            pc_en       = 1'b0;
            en_IF_ID    = 1'b0;
            flush_ID_EX = 1'b1;
            if (LOADUSE_BUBBLES > 1) begin
               state_d = LU_STALL;
               cnt_d   = BUB_CNT_W'(LOADUSE_BUBBLES - 1);
            end else begin
               state_d = RUN;
            end
         end else if (!ihit) begin
            pc_en       = 1'b0;
            flush_IF_ID = 1'b1;
            state_d     = RUN;
         end else begin
            state_d = RUN;
         end
         if (halt_WB) state_d = HALTED;
      end
      if (RST) begin
         pc_en       = 1'b1;
         en_IF_ID    = 1'b1;
         en_ID_EX    = 1'b1;
         en_EX_MEM   = 1'b1;
         en_MEM_WB   = 1'b1;
         flush_IF_ID = 1'b0;
         flush_ID_EX = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign halt    = (state_q == HALTED);
   assign state_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
   logic lu_win, dwait_win, redirect_win;

   // Only the load-use bubble asserts flush_ID_EX alone; only redirect asserts both flushes.
   always_comb begin
      lu_win       = flush_ID_EX & ~flush_IF_ID;
      redirect_win = flush_ID_EX & flush_IF_ID;
      dwait_win    = dwait & ~RST & (state_q != HALTED);
   end

   hazard_perf_counters u_perf (
      .CLK          (CLK),
      .RST          (RST),
      .freeze       (state_q == HALTED),
      .lu_win       (lu_win),
      .dwait_win    (dwait_win),
      .redirect_win (redirect_win),
      .lu_stall_cnt (lu_stall_cnt),
      .dwait_cnt    (dwait_cnt),
      .redirect_cnt (redirect_cnt)
   );
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Table-driven bench for hazard_ctrl_unit with LOADUSE_BUBBLES=1 and a second instance with 3.
module tb_hazard_ctrl_unit;
   import cpu_types_pkg::*;

   logic CLK;
   hazard_ctrl_if hif ();

   logic       p3_pc_en, p3_en_IF_ID, p3_en_ID_EX, p3_en_EX_MEM, p3_en_MEM_WB;
   logic       p3_flush_IF_ID, p3_flush_ID_EX, p3_halt;
   logic [2:0] p3_state;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] p3_lu_cnt, p3_dw_cnt, p3_rd_cnt;
`endif

   int nCompared = 0;
   int nMismatched = 0;

   // Output patterns: {pc_en, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB, flush_IF_ID, flush_ID_EX}
   localparam logic [6:0] O_ALL1  = 7'b1111100;
   localparam logic [6:0] O_FRZ   = 7'b0000000;
   localparam logic [6:0] O_BUB   = 7'b0011101;
   localparam logic [6:0] O_RED   = 7'b1111111;
   localparam logic [6:0] O_IMISS = 7'b0111110;

   typedef struct {
      string       name;
      logic        dut;
      logic        rst;
      logic [1:0]  lu;
      logic [1:0]  dw;
      logic        redir;
      logic        ihit;
      logic        hw;
      logic [10:0] exp;
   } vec_t;

   vec_t vecs[$];

   hazard_ctrl_unit #(.LOADUSE_BUBBLES(1), .BUB_CNT_W(3)) dut (
      .CLK         (CLK),
      .RST         (hif.RST),
      .rs1_ID      (hif.rs1_ID),
      .rs2_ID      (hif.rs2_ID),
      .wsel_EX     (hif.wsel_EX),
      .MemRead_EX  (hif.MemRead_EX),
      .RegWr_EX    (hif.RegWr_EX),
      .dREN_MEM    (hif.dREN_MEM),
      .dWEN_MEM    (hif.dWEN_MEM),
      .dhit        (hif.dhit),
      .ihit        (hif.ihit),
      .redirect_EX (hif.redirect_EX),
      .halt_WB     (hif.halt_WB),
      .pc_en       (hif.pc_en),
      .en_IF_ID    (hif.en_IF_ID),
      .en_ID_EX    (hif.en_ID_EX),
      .en_EX_MEM   (hif.en_EX_MEM),
      .en_MEM_WB   (hif.en_MEM_WB),
      .flush_IF_ID (hif.flush_IF_ID),
      .flush_ID_EX (hif.flush_ID_EX),
      .halt        (hif.halt),
      .state_o     (hif.state_o)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .lu_stall_cnt (hif.lu_stall_cnt),
      .dwait_cnt    (hif.dwait_cnt),
      .redirect_cnt (hif.redirect_cnt)
`endif
   );

   hazard_ctrl_unit #(.LOADUSE_BUBBLES(3), .BUB_CNT_W(3)) dut3 (
      .CLK         (CLK),
      .RST         (hif.RST),
      .rs1_ID      (hif.rs1_ID),
      .rs2_ID      (hif.rs2_ID),
      .wsel_EX     (hif.wsel_EX),
      .MemRead_EX  (hif.MemRead_EX),
      .RegWr_EX    (hif.RegWr_EX),
      .dREN_MEM    (hif.dREN_MEM),
      .dWEN_MEM    (hif.dWEN_MEM),
      .dhit        (hif.dhit),
      .ihit        (hif.ihit),
      .redirect_EX (hif.redirect_EX),
      .halt_WB     (hif.halt_WB),
      .pc_en       (p3_pc_en),
      .en_IF_ID    (p3_en_IF_ID),
      .en_ID_EX    (p3_en_ID_EX),
      .en_EX_MEM   (p3_en_EX_MEM),
      .en_MEM_WB   (p3_en_MEM_WB),
      .flush_IF_ID (p3_flush_IF_ID),
      .flush_ID_EX (p3_flush_ID_EX),
      .halt        (p3_halt),
      .state_o     (p3_state)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .lu_stall_cnt (p3_lu_cnt),
      .dwait_cnt    (p3_dw_cnt),
      .redirect_cnt (p3_rd_cnt)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic vec_t mk(input string nm, input logic d, input logic r,
                               input logic [1:0] lu, input logic [1:0] dw,
                               input logic rd, input logic ih, input logic hw,
                               input logic [6:0] o, input logic h, input logic [2:0] st);
      vec_t v;
      v.name = nm; v.dut = d; v.rst = r; v.lu = lu; v.dw = dw;
      v.redir = rd; v.ihit = ih; v.hw = hw; v.exp = {o, h, st};
      return v;
   endfunction

   // lu: 0 none, 1 load to x5 with rs2=x5, 2 load to x0 with rs1=x0; dw: 0 idle, 1 read wait, 2 read hit, 3 write wait
   task automatic applyStimulus(input vec_t v);
      @(negedge CLK);
      hif.RST         = v.rst;
      hif.redirect_EX = v.redir;
      hif.ihit        = v.ihit;
      hif.halt_WB     = v.hw;
      case (v.lu)
         2'd1: begin
            hif.MemRead_EX = 1'b1; hif.RegWr_EX = 1'b1;
            hif.wsel_EX = 5'd5; hif.rs1_ID = 5'd1; hif.rs2_ID = 5'd5;
         end
         2'd2: begin
            hif.MemRead_EX = 1'b1; hif.RegWr_EX = 1'b1;
            hif.wsel_EX = 5'd0; hif.rs1_ID = 5'd0; hif.rs2_ID = 5'd3;
         end
         default: begin
            hif.MemRead_EX = 1'b0; hif.RegWr_EX = 1'b0;
            hif.wsel_EX = 5'd0; hif.rs1_ID = 5'd1; hif.rs2_ID = 5'd2;
         end
      endcase
      case (v.dw)
         2'd1:    begin hif.dREN_MEM = 1'b1; hif.dWEN_MEM = 1'b0; hif.dhit = 1'b0; end
         2'd2:    begin hif.dREN_MEM = 1'b1; hif.dWEN_MEM = 1'b0; hif.dhit = 1'b1; end
         2'd3:    begin hif.dREN_MEM = 1'b0; hif.dWEN_MEM = 1'b1; hif.dhit = 1'b0; end
         default: begin hif.dREN_MEM = 1'b0; hif.dWEN_MEM = 1'b0; hif.dhit = 1'b0; end
      endcase
      #1;
   endtask

   task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %b, expected %b", nm, act, exp);
      end
   endtask

   function automatic logic [10:0] packMain();
      return {hif.pc_en, hif.en_IF_ID, hif.en_ID_EX, hif.en_EX_MEM, hif.en_MEM_WB,
              hif.flush_IF_ID, hif.flush_ID_EX, hif.halt, hif.state_o};
   endfunction

   function automatic logic [10:0] packDut3();
      return {p3_pc_en, p3_en_IF_ID, p3_en_ID_EX, p3_en_EX_MEM, p3_en_MEM_WB,
              p3_flush_IF_ID, p3_flush_ID_EX, p3_halt, p3_state};
   endfunction

   initial begin
      // Main instance, LOADUSE_BUBBLES=1
      vecs.push_back(mk("reset",       0, 1, 0, 0, 0, 1, 0, O_ALL1,  0, 3'd0));
      vecs.push_back(mk("idle",        0, 0, 0, 0, 0, 1, 0, O_ALL1,  0, 3'd0));
      vecs.push_back(mk("lu_detect",   0, 0, 1, 0, 0, 1, 0, O_BUB,   0, 3'd0));
      vecs.push_back(mk("lu_done",     0, 0, 0, 0, 0, 1, 0, O_ALL1,  0, 3'd0));
      vecs.push_back(mk("reg_zero",    0, 0, 2, 0, 0, 1, 0, O_ALL1,  0, 3'd0));
      vecs.push_back(mk("dwait_1",     0, 0, 0, 1, 0, 1, 0, O_FRZ,   0, 3'd0));
      vecs.push_back(mk("dwait_2_wr",  0, 0, 0, 3, 0, 1, 0, O_FRZ,   0, 3'd2));
      vecs.push_back(mk("dwait_3",     0, 0, 0, 1, 0, 1, 0, O_FRZ,   0, 3'd2));
      vecs.push_back(mk("dwait_4",     0, 0, 0, 1, 0, 1, 0, O_FRZ,   0, 3'd2));
      vecs.push_back(mk("dhit_rel",    0, 0, 0, 2, 0, 1, 0, O_ALL1,  0, 3'd2));
      vecs.push_back(mk("after_dhit",  0, 0, 0, 0, 0, 1, 0, O_ALL1,  0, 3'd0));
      vecs.push_back(mk("redir_lu",    0, 0, 1, 0, 1, 1, 0, O_RED,   0, 3'd0));
      vecs.push_back(mk("after_redir", 0, 0, 0, 0, 0, 1, 0, O_ALL1,  0, 3'd0));
      vecs.push_back(mk("rd_dw_1",     0, 0, 0, 1, 1, 1, 0, O_FRZ,   0, 3'd0));
      vecs.push_back(mk("rd_dw_2",     0, 0, 0, 1, 1, 1, 0, O_FRZ,   0, 3'd2));
      vecs.push_back(mk("rd_dhit",     0, 0, 0, 2, 1, 1, 0, O_RED,   0, 3'd2));
      vecs.push_back(mk("rd_after",    0, 0, 0, 0, 0, 1, 0, O_ALL1,  0, 3'd0));
      vecs.push_back(mk("imiss_1",     0, 0, 0, 0, 0, 0, 0, O_IMISS, 0, 3'd0));
      vecs.push_back(mk("imiss_2",     0, 0, 0, 0, 0, 0, 0, O_IMISS, 0, 3'd0));
      vecs.push_back(mk("imiss_done",  0, 0, 0, 0, 0, 1, 0, O_ALL1,  0, 3'd0));
      vecs.push_back(mk("halt_wb",     0, 0, 0, 0, 0, 1, 1, O_ALL1,  0, 3'd0));
      vecs.push_back(mk("halted_1",    0, 0, 0, 0, 0, 1, 0, O_FRZ,   1, 3'd3));
      vecs.push_back(mk("halted_lu",   0, 0, 1, 0, 1, 1, 0, O_FRZ,   1, 3'd3));
      vecs.push_back(mk("halt_rst",    0, 1, 0, 0, 0, 1, 0, O_ALL1,  1, 3'd3));
      vecs.push_back(mk("post_rst",    0, 0, 0, 0, 0, 1, 0, O_ALL1,  0, 3'd0));
      // Second instance, LOADUSE_BUBBLES=3
      vecs.push_back(mk("b3_reset",    1, 1, 0, 0, 0, 1, 0, O_ALL1,  0, 3'd0));
      vecs.push_back(mk("b3_bub1",     1, 0, 1, 0, 0, 1, 0, O_BUB,   0, 3'd0));
      vecs.push_back(mk("b3_bub2",     1, 0, 0, 0, 0, 1, 0, O_BUB,   0, 3'd1));
      vecs.push_back(mk("b3_bub3",     1, 0, 0, 0, 0, 1, 0, O_BUB,   0, 3'd1));
      vecs.push_back(mk("b3_run",      1, 0, 0, 0, 0, 1, 0, O_ALL1,  0, 3'd0));
      vecs.push_back(mk("b3_lu_again", 1, 0, 1, 0, 0, 1, 0, O_BUB,   0, 3'd0));
      vecs.push_back(mk("b3_dw_in_lu", 1, 0, 0, 1, 0, 1, 0, O_FRZ,   0, 3'd1));
      vecs.push_back(mk("b3_dhit",     1, 0, 0, 2, 0, 1, 0, O_ALL1,  0, 3'd2));
      vecs.push_back(mk("b3_resume2",  1, 0, 0, 0, 0, 1, 0, O_BUB,   0, 3'd1));
      vecs.push_back(mk("b3_resume3",  1, 0, 0, 0, 0, 1, 0, O_BUB,   0, 3'd1));
      vecs.push_back(mk("b3_run2",     1, 0, 0, 0, 0, 1, 0, O_ALL1,  0, 3'd0));
      vecs.push_back(mk("b3_lu_rst",   1, 0, 1, 0, 0, 1, 0, O_BUB,   0, 3'd0));
      vecs.push_back(mk("b3_rst_mid",  1, 1, 0, 0, 0, 1, 0, O_ALL1,  0, 3'd1));
      vecs.push_back(mk("b3_post_rst", 1, 0, 0, 0, 0, 1, 0, O_ALL1,  0, 3'd0));

      hif.RST = 1'b1; hif.ihit = 1'b1; hif.redirect_EX = 1'b0; hif.halt_WB = 1'b0;
      hif.MemRead_EX = 1'b0; hif.RegWr_EX = 1'b0; hif.wsel_EX = 5'd0;
      hif.rs1_ID = 5'd1; hif.rs2_ID = 5'd2;
      hif.dREN_MEM = 1'b0; hif.dWEN_MEM = 1'b0; hif.dhit = 1'b0;
      $display("[TB] starting hazard_ctrl_unit vectors");

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         if (vecs[i].dut) checkOutput(vecs[i].name, 32'(packDut3()), 32'(vecs[i].exp));
         else             checkOutput(vecs[i].name, 32'(packMain()), 32'(vecs[i].exp));
      end

      // Halt stays sticky regardless of what the pipeline inputs do afterwards
      applyStimulus(mk("s_rst", 0, 1, 0, 0, 0, 1, 0, O_ALL1, 0, 3'd0));
      applyStimulus(mk("s_hw",  0, 0, 0, 0, 0, 1, 1, O_ALL1, 0, 3'd0));
      for (int k = 0; k < 4; k++) begin
         applyStimulus(mk("s_hold", 0, 0, 2'(k), 2'(k), k[0], k[1], 0, O_FRZ, 1, 3'd3));
         checkOutput("halt_sticky", 32'({hif.pc_en, hif.en_MEM_WB, hif.flush_ID_EX, hif.halt, hif.state_o}),
                     32'({1'b0, 1'b0, 1'b0, 1'b1, 3'd3}));
      end

`ifdef HAZARD_PERF_CNT_EN
      applyStimulus(mk("p_rst", 0, 1, 0, 0, 0, 1, 0, O_ALL1, 0, 3'd0));
      applyStimulus(mk("p_idle", 0, 0, 0, 0, 0, 1, 0, O_ALL1, 0, 3'd0));
      checkOutput("perf_reset", 32'(hif.lu_stall_cnt | hif.dwait_cnt | hif.redirect_cnt), 32'd0);
      applyStimulus(mk("p_lu",  0, 0, 1, 0, 0, 1, 0, O_BUB,  0, 3'd0));
      applyStimulus(mk("p_dw1", 0, 0, 0, 1, 0, 1, 0, O_FRZ,  0, 3'd0));
      applyStimulus(mk("p_dw2", 0, 0, 0, 1, 0, 1, 0, O_FRZ,  0, 3'd2));
      applyStimulus(mk("p_rd",  0, 0, 0, 2, 1, 1, 0, O_RED,  0, 3'd2));
      applyStimulus(mk("p_hw",  0, 0, 0, 0, 0, 1, 1, O_ALL1, 0, 3'd0));
      applyStimulus(mk("p_h1",  0, 0, 1, 1, 1, 1, 0, O_FRZ,  1, 3'd3));
      applyStimulus(mk("p_h2",  0, 0, 1, 1, 1, 1, 0, O_FRZ,  1, 3'd3));
      checkOutput("perf_lu",    hif.lu_stall_cnt, 32'd1);
      checkOutput("perf_dwait", hif.dwait_cnt,    32'd2);
      checkOutput("perf_redir", hif.redirect_cnt, 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Pipeline sequencing controller for the 5-stage core; one instance per core.
- Companion to the forwarding unit: covers what forwarding cannot resolve (load-use, data-memory wait, instruction-fetch miss, branch/jump redirect, halt).
- Drives per-stage latch enables, per-stage flushes and PC enable.
- Multi-cycle stalls are sequenced by an FSM plus a bubble counter.

Parameters:
- LOADUSE_BUBBLES, 1, bubbles inserted per load-use hazard (1..7).
- BUB_CNT_W, 3, bubble counter width; must satisfy 2**BUB_CNT_W > LOADUSE_BUBBLES.

Ports:
- CLK  in  1  core clock
- RST  in  1  synchronous, active-high reset
- rs1_ID  in  5  source register 1 of the instruction in ID
- rs2_ID  in  5  source register 2 of the instruction in ID
- wsel_EX  in  5  destination register of the instruction in EX
- MemRead_EX  in  1  instruction in EX is a load
- RegWr_EX  in  1  instruction in EX writes the register file
- dREN_MEM  in  1  data read active in MEM
- dWEN_MEM  in  1  data write active in MEM
- dhit  in  1  data memory access done this cycle
- ihit  in  1  instruction fetch done this cycle
- redirect_EX  in  1  taken branch mispredict or jump resolved in EX
- halt_WB  in  1  halt instruction reached WB
- pc_en  out  1  PC register update enable
- en_IF_ID  out  1  IF/ID latch enable
- en_ID_EX  out  1  ID/EX latch enable
- en_EX_MEM  out  1  EX/MEM latch enable
- en_MEM_WB  out  1  MEM/WB latch enable
- flush_IF_ID  out  1  load a bubble into IF/ID
- flush_ID_EX  out  1  load a bubble into ID/EX
- halt  out  1  sticky core halted
- state_o  out  3  current FSM state (debug)

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Reset values: state=RUN, bubble counter=0, halt=0.
  - Outputs while RST is high: all enables 1, all flushes 0.
  - RST asserted mid-stall returns to RUN on the next edge.
- Outputs are combinational from the current state and the current inputs; transitions occur on the CLK edge.
- FSM states: RUN, LU_STALL, DWAIT, HALTED.
- Priority within a cycle, highest first: HALTED > DWAIT condition > redirect > load-use > ifetch miss.
- dwait condition: (dREN_MEM | dWEN_MEM) & ~dhit.
  - Output: all enables 0, pc_en 0, no flushes.
  - State: go to DWAIT (from RUN or LU_STALL; a LU_STALL count is preserved).
  - In DWAIT: hold while dwait persists. On the dhit cycle, all enables are 1 and the FSM returns to the saved return state (RUN, or LU_STALL if the count is nonzero).
  - A redirect_EX or load-use arriving during DWAIT is held by the frozen EX stage and evaluated after release.
- redirect_EX in RUN or LU_STALL:
  - Outputs: pc_en 1, flush_IF_ID 1, flush_ID_EX 1, other enables 1.
  - State: go to RUN and clear the counter. The flushed dependent instruction cancels any load-use stall.
- Load-use condition: MemRead_EX & RegWr_EX & wsel_EX!=0 & (wsel_EX==rs1_ID | wsel_EX==rs2_ID).
  - Detection cycle counts as bubble 1: pc_en 0, en_IF_ID 0, flush_ID_EX 1.
  - If LOADUSE_BUBBLES>1: go to LU_STALL with counter=LOADUSE_BUBBLES-1.
  - Each LU_STALL cycle repeats the bubble outputs and decrements the counter; return to RUN at 0.
  - With the default of 1, LU_STALL is never entered.
- Ifetch miss (~ihit in RUN, no higher-priority event):
  - Outputs: pc_en 0, flush_IF_ID 1, downstream enables 1.
- halt_WB:
  - Go to HALTED; halt becomes 1 from the next cycle.
  - In HALTED: all enables 0, all flushes 0, and the FSM stays until RST.
- Register 0 never triggers a stall.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, add three outputs, lu_stall_cnt, dwait_cnt and redirect_cnt, each 32 bits.
  - Each counts the cycles in which the corresponding condition won priority.
  - Counters saturate at 0xFFFFFFFF, clear on RST and freeze in HALTED.
- When undefined: no ports and no counter logic.

Decomposition:
- cpu_types_pkg gains:
  - hazard_state_t: 3-bit enum RUN=0, LU_STALL=1, DWAIT=2, HALTED=3.
  - regbits_t: 5-bit register index.
- Interface hazard_ctrl_if carries all non-clock ports, with a ctrl modport and a tb modport.
- One sub-module, hazard_perf_counters, instantiated only under HAZARD_PERF_CNT_EN.

Test Plan:
- Load-use: MemRead_EX=1, RegWr_EX=1, wsel_EX=5, rs2_ID=5.
  - Expect exactly 1 cycle of pc_en=0, en_IF_ID=0, flush_ID_EX=1, then RUN.
  - With LOADUSE_BUBBLES=3, expect 3 such cycles.
- Register zero: wsel_EX=0 with rs1_ID=0 and a load in EX → no stall.
- Data wait: dREN_MEM=1, dhit low for 4 cycles then high.
  - Expect 4 cycles of all enables 0, then all enables 1 on the dhit cycle; state_o shows 2 then 0.
- Redirect during load-use: redirect_EX=1 together with a load-use match.
  - Expect flush_IF_ID=1, flush_ID_EX=1, pc_en=1, no stall.
  - Same redirect with dwait active: freeze wins; the flush occurs on the dhit cycle.
- Ifetch miss: ihit=0 for 2 cycles → pc_en=0, flush_IF_ID=1, en_ID_EX=1.
- Halt and reset: halt_WB pulse → halt=1 sticky and enables 0.
  - RST high for 1 cycle → state RUN, halt=0, perf counters 0 (when enabled).
